// File: rtl/adder_tree_pkg.sv
// adder_tree_pkg: shared types and sizing helpers for the pipelined adder tree.
package adder_tree_pkg;
   typedef enum logic [1:0] {
      OUT_FULL  = 2'd0,
      OUT_TRUNC = 2'd1,
      OUT_SAT   = 2'd2
   } out_mode_e;
   function automatic int tree_levels(input int n);
      return (n <= 1) ? 0 : $clog2(n);
   endfunction
   function automatic int tree_latency(input int n, input int reg_every);
      int l;
      l = tree_levels(n);
      return (l == 0) ? 1 : (l + reg_every - 1) / reg_every;
   endfunction
   function automatic int sum_width(input int w, input int n);
      return w + tree_levels(n);
   endfunction
   // Operand count entering level l of the tree.
   function automatic int level_count(input int n, input int l);
      return (n + (1 << l) - 1) >> l;
   endfunction
endpackage

// File: rtl/pipelined_adder_tree_level.sv
// adder_tree_level: one pairwise reduction level (N in, ceil(N/2) out, +1 bit),
// optionally registered with valid tracking and an ena stall.
module adder_tree_level
   import adder_tree_pkg::*;
#(
   parameter int N          = 2,
   parameter int W          = 16,
   parameter int IS_SIGNED  = 0,
   parameter int REGISTERED = 1,
   localparam int NO        = (N + 1) / 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic         in_valid,
   input  logic [W-1:0] din [N],
   output logic         out_valid,
   output logic [W:0]   dout [NO]
);
   logic [W:0] sum [NO];
   function automatic logic [W:0] ext(input logic [W-1:0] x);
      return {IS_SIGNED != 0 && x[W-1], x};
   endfunction
   for (genvar j = 0; j < NO; j++) begin : pair
      if (2 * j + 1 < N) begin : add
         assign sum[j] = ext(din[2*j]) + ext(din[2*j+1]);
      end else begin : pass
         assign sum[j] = ext(din[2*j]);
      end
   end
   if (REGISTERED != 0) begin : g_reg
      // Data loads only on valid beats so bubbles keep the last result.
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            out_valid <= 1'b0;
            dout      <= '{default: '0};
         end else if (ena) begin
            out_valid <= in_valid;
            if (in_valid) dout <= sum;
         end
   end else begin : g_comb
      assign out_valid = in_valid;
      assign dout      = sum;
   end
endmodule

// File: rtl/pipelined_adder_tree.sv
// pipelined_adder_tree: N-input pipelined reduction with full/wrap/saturate output.
// ADDER_TREE_OVF_EN adds an ovf output flagging sums outside the WIDTH_IN range.
module pipelined_adder_tree
   import adder_tree_pkg::*;
#(
   parameter int NUM_INPUT  = 7,
   parameter int WIDTH_IN   = 16,
   parameter int IS_SIGNED  = 0,
   parameter int OUT_MODE   = 0,
   parameter int REG_EVERY  = 1,
   localparam int LEVELS    = tree_levels(NUM_INPUT),
   localparam int WIDTH_SUM = sum_width(WIDTH_IN, NUM_INPUT),
   localparam int WIDTH_OUT = (OUT_MODE == int'(OUT_FULL)) ? WIDTH_SUM : WIDTH_IN,
   localparam int LATENCY   = tree_latency(NUM_INPUT, REG_EVERY)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic                 in_valid,
   input  logic [WIDTH_IN-1:0]  din [NUM_INPUT],
   output logic                 out_valid,
   output logic [WIDTH_OUT-1:0] dout
`ifdef ADDER_TREE_OVF_EN
   ,
   output logic                 ovf
`endif
);
   logic [WIDTH_SUM-1:0] sum;
   logic                 sum_valid;
   for (genvar g = 0; g < LEVELS; g++) begin : lvl
      localparam int N = level_count(NUM_INPUT, g);
      localparam int W = WIDTH_IN + g;
      localparam int R = ((g + 1) % REG_EVERY == 0 || g == LEVELS - 1) ? 1 : 0;
      logic [W:0] lout [(N + 1) / 2];
      logic       vout;
      if (g == 0) begin : src
         adder_tree_level #(.N(N), .W(W), .IS_SIGNED(IS_SIGNED), .REGISTERED(R)) u_level (
            .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .din(din),
            .out_valid(vout), .dout(lout));
      end else begin : src
         adder_tree_level #(.N(N), .W(W), .IS_SIGNED(IS_SIGNED), .REGISTERED(R)) u_level (
            .clk(clk), .rst(rst), .ena(ena), .in_valid(lvl[g-1].vout), .din(lvl[g-1].lout),
            .out_valid(vout), .dout(lout));
      end
   end
   if (LEVELS == 0) begin : g_one
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            sum_valid <= 1'b0;
            sum       <= '0;
         end else if (ena) begin
            sum_valid <= in_valid;
            if (in_valid) sum <= din[0];
         end
   end else begin : g_tree
      assign sum       = lvl[LEVELS-1].lout[0];
      assign sum_valid = lvl[LEVELS-1].vout;
   end
   assign out_valid = sum_valid;
   if (OUT_MODE == int'(OUT_FULL)) begin : g_full
      assign dout = sum;
`ifdef ADDER_TREE_OVF_EN
      assign ovf = 1'b0;
`endif
   end else begin : g_narrow
      logic                fits;
      logic [WIDTH_IN-1:0] sat;
      // Signed fits when the bits above the result sign all match it.
      assign fits = (IS_SIGNED != 0)
         ? (&sum[WIDTH_SUM-1:WIDTH_IN-1] | ~|sum[WIDTH_SUM-1:WIDTH_IN-1])
         : ~|(sum >> WIDTH_IN);
      assign sat  = (IS_SIGNED != 0 && sum[WIDTH_SUM-1])
         ? {1'b1, {(WIDTH_IN-1){1'b0}}}
         : {IS_SIGNED == 0, {(WIDTH_IN-1){1'b1}}};
      assign dout = (OUT_MODE == int'(OUT_SAT) && !fits) ? sat : sum[WIDTH_IN-1:0];
`ifdef ADDER_TREE_OVF_EN
      assign ovf = !fits;
`endif
   end
endmodule

// File: tb/tb_pipelined_adder_tree.sv
// tb_pipelined_adder_tree: directed vector bench across seven tree configurations.
module tb_pipelined_adder_tree;
   import adder_tree_pkg::*;
   typedef struct {
      logic [6:0][15:0] d;
      logic [18:0]      full, sfull, five;
      logic [15:0]      trunc, usat, ssat, one;
      logic [2:0]       ovf;
   } vec_t;
   typedef struct {
      logic        e, v;
      logic [15:0] x;
   } step_t;
   logic        clk = 1'b0, rst = 1'b1, ena = 1'b0, in_valid = 1'b0;
   logic [15:0] din [7];
   logic [15:0] d1 [1];
   logic [15:0] d5 [5];
   logic        v_full, v_sfull, v_trunc, v_usat, v_ssat, v_one, v_five;
   logic [18:0] o_full, o_sfull, o_five;
   logic [15:0] o_trunc, o_usat, o_ssat, o_one;
`ifdef ADDER_TREE_OVF_EN
   logic        f_full, f_sfull, f_trunc, f_usat, f_ssat, f_one, f_five;
`endif
   int          passed = 0, total = 0;
   vec_t        tv [8];
   vec_t        tv_ones;
   step_t       st [10];
   always #5 clk = ~clk;
   assign d1[0] = din[0];
   always_comb for (int i = 0; i < 5; i++) d5[i] = din[i];

   pipelined_adder_tree u_full (.clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .din(din),
      .out_valid(v_full), .dout(o_full)
`ifdef ADDER_TREE_OVF_EN
      , .ovf(f_full)
`endif
   );
   pipelined_adder_tree #(.IS_SIGNED(1)) u_sfull (.clk(clk), .rst(rst), .ena(ena),
      .in_valid(in_valid), .din(din), .out_valid(v_sfull), .dout(o_sfull)
`ifdef ADDER_TREE_OVF_EN
      , .ovf(f_sfull)
`endif
   );
   pipelined_adder_tree #(.OUT_MODE(1)) u_trunc (.clk(clk), .rst(rst), .ena(ena),
      .in_valid(in_valid), .din(din), .out_valid(v_trunc), .dout(o_trunc)
`ifdef ADDER_TREE_OVF_EN
      , .ovf(f_trunc)
`endif
   );
   pipelined_adder_tree #(.OUT_MODE(2)) u_usat (.clk(clk), .rst(rst), .ena(ena),
      .in_valid(in_valid), .din(din), .out_valid(v_usat), .dout(o_usat)
`ifdef ADDER_TREE_OVF_EN
      , .ovf(f_usat)
`endif
   );
   pipelined_adder_tree #(.IS_SIGNED(1), .OUT_MODE(2)) u_ssat (.clk(clk), .rst(rst), .ena(ena),
      .in_valid(in_valid), .din(din), .out_valid(v_ssat), .dout(o_ssat)
`ifdef ADDER_TREE_OVF_EN
      , .ovf(f_ssat)
`endif
   );
   pipelined_adder_tree #(.NUM_INPUT(1)) u_one (.clk(clk), .rst(rst), .ena(ena),
      .in_valid(in_valid), .din(d1), .out_valid(v_one), .dout(o_one)
`ifdef ADDER_TREE_OVF_EN
      , .ovf(f_one)
`endif
   );
   pipelined_adder_tree #(.NUM_INPUT(5), .REG_EVERY(2)) u_five (.clk(clk), .rst(rst), .ena(ena),
      .in_valid(in_valid), .din(d5), .out_valid(v_five), .dout(o_five)
`ifdef ADDER_TREE_OVF_EN
      , .ovf(f_five)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      else passed++;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int lat_full = 0, lat_one = 0, lat_five = 0, np = 0;
      @(negedge clk);
      for (int i = 0; i < 7; i++) din[i] = v.d[i];
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         if (k > 1) @(negedge clk);
         if (v_full) begin
            np++;
            if (lat_full == 0) lat_full = k;
         end
         if (v_one && lat_one == 0) lat_one = k;
         if (v_five && lat_five == 0) lat_five = k;
      end
      check($sformatf("v%0d lat_full", idx), lat_full, 3);
      check($sformatf("v%0d pulses_full", idx), np, 1);
      check($sformatf("v%0d lat_one", idx), lat_one, 1);
      check($sformatf("v%0d lat_five", idx), lat_five, 2);
      check($sformatf("v%0d full", idx), o_full, v.full);
      check($sformatf("v%0d sfull", idx), o_sfull, v.sfull);
      check($sformatf("v%0d trunc", idx), o_trunc, v.trunc);
      check($sformatf("v%0d usat", idx), o_usat, v.usat);
      check($sformatf("v%0d ssat", idx), o_ssat, v.ssat);
      check($sformatf("v%0d one", idx), o_one, v.one);
      check($sformatf("v%0d five", idx), o_five, v.five);
`ifdef ADDER_TREE_OVF_EN
      check($sformatf("v%0d ovf_full", idx), f_full, 0);
      check($sformatf("v%0d ovf_trunc", idx), f_trunc, v.ovf[0]);
      check($sformatf("v%0d ovf_usat", idx), f_usat, v.ovf[1]);
      check($sformatf("v%0d ovf_ssat", idx), f_ssat, v.ovf[2]);
`endif
   endtask

   initial begin
      logic [18:0] full_exp [3], five_exp [3], last;
      logic [15:0] one_exp [3];
      int          nf, n5, n1, np;
      tv[0] = '{d: {7{16'hFFFF}}, full: 19'h6FFF9, sfull: 19'h7FFF9, five: 19'h4FFFB,
                trunc: 16'hFFF9, usat: 16'hFFFF, ssat: 16'hFFF9, one: 16'hFFFF, ovf: 3'b011};
      tv[1] = '{d: {7{16'h0000}}, full: 19'h0, sfull: 19'h0, five: 19'h0,
                trunc: 16'h0, usat: 16'h0, ssat: 16'h0, one: 16'h0, ovf: 3'b000};
      tv[2] = '{d: {7{16'h8000}}, full: 19'h38000, sfull: 19'h48000, five: 19'h28000,
                trunc: 16'h8000, usat: 16'hFFFF, ssat: 16'h8000, one: 16'h8000, ovf: 3'b111};
      tv[3] = '{d: {7{16'h7FFF}}, full: 19'h37FF9, sfull: 19'h37FF9, five: 19'h27FFB,
                trunc: 16'h7FF9, usat: 16'hFFFF, ssat: 16'h7FFF, one: 16'h7FFF, ovf: 3'b111};
      tv[4] = '{d: {16'd5, 16'hFFFF, 16'd1, 16'hFFFF, 16'd1, 16'hFFFF, 16'd1},
                full: 19'h30005, sfull: 19'h5, five: 19'h20001,
                trunc: 16'h5, usat: 16'hFFFF, ssat: 16'h5, one: 16'h1, ovf: 3'b011};
      tv[5] = '{d: {7{16'd100}}, full: 19'd700, sfull: 19'd700, five: 19'd500,
                trunc: 16'd700, usat: 16'd700, ssat: 16'd700, one: 16'd100, ovf: 3'b000};
      tv[6] = '{d: {16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
                full: 19'd28, sfull: 19'd28, five: 19'd15,
                trunc: 16'd28, usat: 16'd28, ssat: 16'd28, one: 16'd1, ovf: 3'b000};
      tv[7] = '{d: {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd3, 16'hFFFE},
                full: 19'h10001, sfull: 19'h1, five: 19'h10001,
                trunc: 16'h1, usat: 16'hFFFF, ssat: 16'h1, one: 16'hFFFE, ovf: 3'b011};
      tv_ones = '{d: {7{16'd1}}, full: 19'd7, sfull: 19'd7, five: 19'd5,
                  trunc: 16'd7, usat: 16'd7, ssat: 16'd7, one: 16'd1, ovf: 3'b000};
      st[0] = '{1'b1, 1'b1, 16'h0010};
      st[1] = '{1'b1, 1'b1, 16'h0200};
      st[2] = '{1'b0, 1'b1, 16'hFFFF};
      st[3] = '{1'b0, 1'b1, 16'hFFFF};
      st[4] = '{1'b1, 1'b1, 16'h3000};
      for (int i = 5; i < 10; i++) st[i] = '{1'b1, 1'b0, 16'hFFFF};
      full_exp = '{19'h70, 19'hE00, 19'h15000};
      five_exp = '{19'h50, 19'hA00, 19'hF000};
      one_exp  = '{16'h10, 16'h200, 16'h3000};
      for (int i = 0; i < 7; i++) din[i] = 16'h0;

      @(negedge clk);
      check("reset out_valid", v_full, 0);
      check("reset dout", o_full, 0);
      check("reset dout_one", o_one, 0);
      rst = 1'b0;
      ena = 1'b1;
      for (int i = 0; i < 8; i++) run_vec(tv[i], i);

      // Two beats in the pipe plus one presented as reset rises.
      for (int b = 1; b <= 3; b++) begin
         @(negedge clk);
         for (int i = 0; i < 7; i++) din[i] = 16'(b);
         in_valid = 1'b1;
         if (b == 3) begin
            rst = 1'b1;
            #1;
            check("rst async out_valid", v_full, 0);
            check("rst async dout", o_full, 0);
            check("rst async dout_five", o_five, 0);
         end
      end
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      np = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         np += int'(v_full) + int'(v_five) + int'(v_one);
      end
      check("rst discards beats", np, 0);
      run_vec(tv_ones, 99);

      nf = 0; n5 = 0; n1 = 0;
      last = 19'd7;
      for (int s = 0; s <= 10; s++) begin
         @(negedge clk);
         if (s > 0) begin
            if (st[s-1].e && v_full) begin
               if (nf < 3) last = full_exp[nf];
               else check("stall extra pulse_full", 1, 0);
               nf++;
            end
            if (!st[s-1].e) check($sformatf("stall s%0d no pulse", s), v_full, 0);
            check($sformatf("stall s%0d hold_full", s), o_full, last);
            if (st[s-1].e && v_five) begin
               if (n5 < 3) check($sformatf("stall five #%0d", n5), o_five, five_exp[n5]);
               else check("stall extra pulse_five", 1, 0);
               n5++;
            end
            if (st[s-1].e && v_one) begin
               if (n1 < 3) check($sformatf("stall one #%0d", n1), o_one, one_exp[n1]);
               else check("stall extra pulse_one", 1, 0);
               n1++;
            end
         end
         if (s < 10) begin
            ena = st[s].e;
            in_valid = st[s].v;
            for (int i = 0; i < 7; i++) din[i] = st[s].x;
         end
      end
      check("stall pulses_full", nf, 3);
      check("stall pulses_five", n5, 3);
      check("stall pulses_one", n1, 3);
      check("bubble hold_full", o_full, 19'h15000);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
